// File: rtl/sharp_lcd_rx.sv
// Panel-side receiver for the Sharp memory-LCD serial link.
// Decodes mode/address/data/dummy fields into line-write and frame events.
module sharp_lcd_rx #(
    parameter int DATA_BITS   = 144,
    parameter int NUM_LINES   = 168,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_12mhz,
    input  logic                 rst,
    input  logic                 SCS,
    input  logic                 SCK,
    input  logic                 SI,
    output logic                 line_valid,
    output logic [7:0]           line_addr,
    output logic [DATA_BITS-1:0] line_data,
    output logic                 vcom,
    output logic                 clear_pulse,
    output logic                 frame_done,
    output logic                 frame_err,
    output logic                 addr_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_MODE, S_ADDR, S_DATA, S_DUMMY, S_TAIL
    } state_t;

    logic [SYNC_STAGES-1:0] scs_sync_q, scs_sync_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] si_sync_q, si_sync_d;
    logic                   scs_prev_q, sck_prev_q;
    logic                   scs_s, sck_s, si_s;
    logic                   scs_rise, scs_fall, sck_rise;

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d, cnt_inc;
    logic [2:0]             mode_q, mode_d;
    logic [7:0]             addr_q, addr_d, addr_new;
    logic [DATA_BITS-1:0]   buf_q, buf_d, buf_new;
    logic                   addr_ok, last8, legal_end;

    logic                   line_valid_q, line_valid_d;
    logic [7:0]             line_addr_q, line_addr_d;
    logic [DATA_BITS-1:0]   line_data_q, line_data_d;
    logic                   vcom_q, vcom_d;
    logic                   clear_q, clear_d;
    logic                   done_q, done_d;
    logic                   ferr_q, ferr_d;
    logic                   aerr_q, aerr_d;

    assign scs_sync_d = {scs_sync_q[SYNC_STAGES-2:0], SCS};
    assign sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], SCK};
    assign si_sync_d  = {si_sync_q[SYNC_STAGES-2:0], SI};

    assign scs_s    = scs_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign si_s     = si_sync_q[SYNC_STAGES-1];
    assign scs_rise = scs_s & ~scs_prev_q;
    assign scs_fall = ~scs_s & scs_prev_q;
    assign sck_rise = sck_s & ~sck_prev_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mode_d       = mode_q;
        addr_d       = addr_q;
        buf_d        = buf_q;
        line_valid_d = 1'b0;
        line_addr_d  = line_addr_q;
        line_data_d  = line_data_q;
        vcom_d       = vcom_q;
        clear_d      = 1'b0;
        done_d       = 1'b0;
        ferr_d       = 1'b0;
        aerr_d       = 1'b0;

        cnt_inc  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        last8    = (cnt_q == 8'd7);
        addr_new = {si_s, addr_q[7:1]};
        buf_new  = {si_s, buf_q[DATA_BITS-1:1]};
        addr_ok  = (addr_q != 8'd0) && (addr_q <= 8'(NUM_LINES));

        // Trailer dummy bits land in ADDR/DATA with address 0
        legal_end = (state_q == S_TAIL)
                  || (state_q == S_ADDR && cnt_q == 8'd0)
                  || (state_q == S_DATA && addr_q == 8'd0
                      && cnt_q <= 8'd8);

        if (scs_fall) begin
            if (state_q != S_IDLE) begin
                done_d = legal_end;
                ferr_d = ~legal_end;
            end
            state_d = S_IDLE;
            cnt_d   = 8'd0;
        end else if (scs_rise) begin
            if (state_q == S_IDLE) begin
                state_d = S_MODE;
                cnt_d   = 8'd0;
            end
        end else if (sck_rise && scs_s) begin
            unique case (state_q)
                S_MODE: begin
                    if (cnt_q < 8'd3) mode_d = {si_s, mode_q[2:1]};
                    cnt_d = cnt_inc;
                    if (last8) begin
                        vcom_d = mode_q[1];
                        cnt_d  = 8'd0;
                        if (mode_q[2]) begin
                            clear_d = 1'b1;
                            state_d = S_TAIL;
                        end else if (!mode_q[0]) begin
                            state_d = S_TAIL;
                        end else begin
                            state_d = S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    addr_d = addr_new;
                    cnt_d  = cnt_inc;
                    if (last8) begin
                        aerr_d  = (addr_new != 8'd0)
                               && (addr_new > 8'(NUM_LINES));
                        state_d = S_DATA;
                        cnt_d   = 8'd0;
                    end
                end
                S_DATA: begin
                    buf_d = buf_new;
                    cnt_d = cnt_inc;
                    if (cnt_q == 8'(DATA_BITS - 1)) begin
                        if (addr_ok) begin
                            line_valid_d = 1'b1;
                            line_addr_d  = addr_q;
                            line_data_d  = buf_new;
                        end
                        state_d = S_DUMMY;
                        cnt_d   = 8'd0;
                    end
                end
                S_DUMMY: begin
                    cnt_d = cnt_inc;
                    if (last8) begin
                        state_d = S_ADDR;
                        cnt_d   = 8'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_12mhz) begin
        if (rst) begin
            scs_sync_q   <= '1;
            sck_sync_q   <= '0;
            si_sync_q    <= '0;
            scs_prev_q   <= 1'b1;
            sck_prev_q   <= 1'b0;
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            mode_q       <= 3'd0;
            addr_q       <= 8'd0;
            buf_q        <= '0;
            line_valid_q <= 1'b0;
            line_addr_q  <= 8'd0;
            line_data_q  <= '0;
            vcom_q       <= 1'b0;
            clear_q      <= 1'b0;
            done_q       <= 1'b0;
            ferr_q       <= 1'b0;
            aerr_q       <= 1'b0;
        end else begin
            scs_sync_q   <= scs_sync_d;
            sck_sync_q   <= sck_sync_d;
            si_sync_q    <= si_sync_d;
            scs_prev_q   <= scs_s;
            sck_prev_q   <= sck_s;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mode_q       <= mode_d;
            addr_q       <= addr_d;
            buf_q        <= buf_d;
            line_valid_q <= line_valid_d;
            line_addr_q  <= line_addr_d;
            line_data_q  <= line_data_d;
            vcom_q       <= vcom_d;
            clear_q      <= clear_d;
            done_q       <= done_d;
            ferr_q       <= ferr_d;
            aerr_q       <= aerr_d;
        end
    end

    assign line_valid  = line_valid_q;
    assign line_addr   = line_addr_q;
    assign line_data   = line_data_q;
    assign vcom        = vcom_q;
    assign clear_pulse = clear_q;
    assign frame_done  = done_q;
    assign frame_err   = ferr_q;
    assign addr_err    = aerr_q;

endmodule
